// File: rtl/median3x3_stream.sv
// median3x3_stream: streaming 3x3 median/min/max/bypass filter emitting the cropped interior of a raster frame.
// Two line buffers feed a column tap register, a 3x3 window, then a three-stage sorting pipeline.
module median3x3_stream #(
   parameter int DW    = 8,
   parameter int IMG_W = 225,
   parameter int IMG_H = 225
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          busy,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_eol,
   output logic          out_last
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H + 1) : 2;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0] lo;
      logic [DW-1:0] md;
      logic [DW-1:0] hi;
   } trio_t;

   function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a < b) ? b : a;
   endfunction

   function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   function automatic trio_t sort3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] c);
      trio_t t;
      t.lo = min2(min2(a, b), c);
      t.md = med3(a, b, c);
      t.hi = max2(max2(a, b), c);
      return t;
   endfunction

   state_t        state_r, state_s;
   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [1:0]    mode_r;
   logic          accept_s, complete_s, at_eol_s, at_last_s;

   logic [DW-1:0] lb0_r [IMG_W];
   logic [DW-1:0] lb1_r [IMG_W];

   logic          tap_v_r, tap_done_r, tap_eol_r, tap_last_r;
   logic [DW-1:0] tap_top_r, tap_mid_r, tap_bot_r;
   logic          win_v_r, win_eol_r, win_last_r;
   logic [DW-1:0] win_r [9];
   logic          s1_v_r, s1_eol_r, s1_last_r;
   trio_t         s1_row_r [3];
   logic [DW-1:0] s1_ctr_r;
   logic          s2_v_r, s2_eol_r, s2_last_r;
   logic [DW-1:0] s2_a_r, s2_b_r, s2_c_r, s2_mn_r, s2_mx_r, s2_ctr_r;
   logic [DW-1:0] res_s;

   assign accept_s   = (state_r == RUN) && in_valid && !start;
   assign complete_s = (col_r >= COL_TWO) && (row_r >= ROW_TWO);
   assign at_eol_s   = (col_r == COL_LAST);
   assign at_last_s  = at_eol_s && (row_r == ROW_LAST);

   // Frame sequencing: a start always re-arms, otherwise RUN -> DRAIN -> IDLE.
   always_comb begin
      state_s = state_r;
      if (start) begin
         state_s = RUN;
      end else begin
         case (state_r)
            IDLE:    state_s = IDLE;
            RUN:     if (accept_s && at_last_s) state_s = DRAIN; else state_s = RUN;
            DRAIN:   if (out_valid && out_last) state_s = IDLE; else state_s = DRAIN;
            default: state_s = IDLE;
         endcase
      end
   end

   // State register and registered busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy    <= (state_s != IDLE);
      end
   end

   // Raster position of the next accepted pixel, and the per-frame operator.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r  <= '0;
         row_r  <= '0;
         mode_r <= 2'd0;
      end else if (start) begin
         col_r  <= '0;
         row_r  <= '0;
         mode_r <= mode;
      end else if (accept_s) begin
         if (at_eol_s) begin
            col_r <= '0;
            row_r <= row_r + ROW_ONE;
         end else begin
            col_r <= col_r + COL_ONE;
         end
      end
   end

   // Line buffers and column tap; reads see the contents from before this edge's write.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         lb0_r[col_r] <= in_data;
         lb1_r[col_r] <= lb0_r[col_r];
         tap_bot_r    <= in_data;
         tap_mid_r    <= lb0_r[col_r];
         tap_top_r    <= lb1_r[col_r];
         tap_eol_r    <= at_eol_s;
         tap_last_r   <= at_last_s;
      end
   end

   // Pipeline valid bits; start flushes anything still in flight from the old frame.
   always_ff @(posedge clk) begin
      if (rst || start) begin
         tap_v_r    <= 1'b0;
         tap_done_r <= 1'b0;
         win_v_r    <= 1'b0;
         s1_v_r     <= 1'b0;
         s2_v_r     <= 1'b0;
      end else begin
         tap_v_r    <= accept_s;
         tap_done_r <= accept_s && complete_s;
         win_v_r    <= tap_done_r;
         s1_v_r     <= win_v_r;
         s2_v_r     <= s1_v_r;
      end
   end

   // Window shift and sorting datapath: row sorts, then max-of-mins / median-of-medians / min-of-maxes.
   always_ff @(posedge clk) begin
      if (tap_v_r) begin
         win_r[0] <= win_r[1];
         win_r[1] <= win_r[2];
         win_r[2] <= tap_top_r;
         win_r[3] <= win_r[4];
         win_r[4] <= win_r[5];
         win_r[5] <= tap_mid_r;
         win_r[6] <= win_r[7];
         win_r[7] <= win_r[8];
         win_r[8] <= tap_bot_r;
      end
      win_eol_r  <= tap_eol_r;
      win_last_r <= tap_last_r;
      for (int i = 0; i < 3; i++) begin
         s1_row_r[i] <= sort3(win_r[3*i], win_r[3*i+1], win_r[3*i+2]);
      end
      s1_ctr_r  <= win_r[4];
      s1_eol_r  <= win_eol_r;
      s1_last_r <= win_last_r;
      s2_a_r    <= max2(max2(s1_row_r[0].lo, s1_row_r[1].lo), s1_row_r[2].lo);
      s2_b_r    <= med3(s1_row_r[0].md, s1_row_r[1].md, s1_row_r[2].md);
      s2_c_r    <= min2(min2(s1_row_r[0].hi, s1_row_r[1].hi), s1_row_r[2].hi);
      s2_mn_r   <= min2(min2(s1_row_r[0].lo, s1_row_r[1].lo), s1_row_r[2].lo);
      s2_mx_r   <= max2(max2(s1_row_r[0].hi, s1_row_r[1].hi), s1_row_r[2].hi);
      s2_ctr_r  <= s1_ctr_r;
      s2_eol_r  <= s1_eol_r;
      s2_last_r <= s1_last_r;
   end

   // Operator selection for the final stage.
   always_comb begin
      res_s = s2_ctr_r;
      case (mode_r)
         2'd0:    res_s = med3(s2_a_r, s2_b_r, s2_c_r);
         2'd1:    res_s = s2_mn_r;
         2'd2:    res_s = s2_mx_r;
         2'd3:    res_s = s2_ctr_r;
         default: res_s = s2_ctr_r;
      endcase
   end

   // Registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_eol   <= 1'b0;
         out_last  <= 1'b0;
      end else if (start) begin
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= s2_v_r;
         out_eol   <= s2_v_r && s2_eol_r;
         out_last  <= s2_v_r && s2_last_r;
         if (s2_v_r) begin
            out_data <= res_s;
         end
      end
   end

endmodule

// File: tb/tb_median3x3_stream.sv
// Self-checking bench for median3x3_stream on 5x5 frames: directed grain images, random gapped frames,
// mid-frame reset and abort, checked against a sort-based reference and a per-output latency target.
module tb_median3x3_stream;

   localparam int DW = 8;
   localparam int W  = 5;
   localparam int H  = 5;

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [1:0]    mode;
   logic [DW-1:0] in_data;
   logic          busy, out_valid, out_eol, out_last;
   logic [DW-1:0] out_data;

   median3x3_stream #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .in_valid(in_valid), .in_data(in_data),
      .busy(busy), .out_valid(out_valid), .out_data(out_data),
      .out_eol(out_eol), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       eol;
      logic       last;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   logic [7:0] img [H][W];
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         last_prev = 1'b0;

   function automatic logic [7:0] ref_pix(input logic [1:0] md, input int orow, input int ocol);
      logic [7:0] v [9];
      logic [7:0] t;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            v[dr*3+dc] = img[orow+dr][ocol+dc];
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      case (md)
         2'd0:    return v[4];
         2'd1:    return v[0];
         2'd2:    return v[8];
         default: return img[orow+1][ocol+1];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
      end
   endtask

   // Output monitor: every out_valid must match the head of the expected queue, on time.
   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b0) begin
         last_prev = 1'b0;
      end else begin
         if (last_prev) begin
            n_cmp++;
            assert (busy === 1'b0) else begin
               n_bad++;
               $error("FAIL busy_after_last: observed %b required 0", busy);
            end
         end
         last_prev = 1'b0;
         if (out_valid === 1'b1) begin
            n_cmp++;
            assert (q.size() != 0) else begin
               n_bad++;
               $error("FAIL unexpected_output: observed data %h at cycle %0d, required no output", out_data, cyc);
            end
            if (q.size() != 0) begin
               e = q.pop_front();
               n_cmp++;
               assert ({out_data, out_eol, out_last} === {e.d, e.eol, e.last}) else begin
                  n_bad++;
                  $error("FAIL pixel: observed data=%h eol=%b last=%b required data=%h eol=%b last=%b",
                         out_data, out_eol, out_last, e.d, e.eol, e.last);
               end
               n_cmp++;
               assert (cyc === e.cyc) else begin
                  n_bad++;
                  $error("FAIL latency: observed cycle %0d required cycle %0d", cyc, e.cyc);
               end
               if (e.last) begin
                  n_cmp++;
                  assert (busy === 1'b1) else begin
                     n_bad++;
                     $error("FAIL busy_at_last: observed %b required 1", busy);
                  end
                  last_prev = 1'b1;
               end
            end
         end
      end
   end

   task automatic do_start(input logic [1:0] md);
      int s;
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      mode     = md;
      s        = cyc;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].cyc > s) q.delete(i);
      @(negedge clk);
      start = 1'b0;
      mode  = ~md;
   endtask

   // gap: 0 full rate, 1 one pixel in four cycles, 2 random idles
   task automatic drive(input logic [1:0] md, input int first, input int count, input int gap);
      for (int idx = first; idx < first + count; idx++) begin
         int r = idx / W;
         int c = idx % W;
         int idles = (gap == 1) ? 3 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
         repeat (idles) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            mode     = 2'($urandom);
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = img[r][c];
         mode     = 2'($urandom);
         if (r >= 2 && c >= 2)
            q.push_back('{d: ref_pix(md, r - 2, c - 2), eol: (c == W - 1),
                          last: (c == W - 1 && r == H - 1), cyc: cyc + 5});
      end
   endtask

   task automatic junk(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
      end
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while ((q.size() != 0 || busy !== 1'b0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_pending_outputs"}, q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_frame(input string tag, input logic [1:0] md, input int gap);
      do_start(md);
      drive(md, 0, W * H, gap);
      wait_drain(tag);
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = v;
   endtask

   task automatic fill_rand(input int lim);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'($urandom_range(0, lim));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_eol"}, out_eol, 0);
      chk({tag, "_out_last"}, out_last, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      chk("start_during_reset_busy", busy, 0);

      fill_const(8'h40);
      run_frame("const_median", 2'd0, 0);

      fill_const(8'h00);
      img[2][2] = 8'hFF;
      for (int m = 0; m < 4; m++)
         run_frame("grain", 2'(m), 0);

      for (int f = 0; f < 24; f++) begin
         fill_rand((f % 4 == 0) ? 3 : 255);
         junk(3);
         do_start(2'(f % 4));
         drive(2'(f % 4), 0, W * H, f % 3);
         junk(3);
         wait_drain("random");
      end

      fill_rand(255);
      do_start(2'd2);
      drive(2'd2, 0, 12, 0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      q.delete();
      @(negedge clk);
      chk_zero("mid_reset");
      rst = 1'b0;
      run_frame("after_reset", 2'd0, 0);

      fill_rand(255);
      do_start(2'd2);
      drive(2'd2, 0, 18, 0);
      do_start(2'd1);
      fill_rand(255);
      drive(2'd1, 0, W * H, 0);
      wait_drain("abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/median3x3_stream.md
# median3x3_stream

Parametrised streaming 3×3 neighbourhood filter for grain removal. It accepts one raster-scan frame of IMG_W×IMG_H pixels and emits the cropped interior frame of (IMG_W−2)×(IMG_H−2) filtered pixels. Each frame is filtered with a per-frame operator: median, min (erosion), max (dilation) or centre-pixel bypass. It sits between the pixel source (image ROM/loader) and the output sink (file writer in simulation, display/UART path in hardware). It generalises the fixed 8-bit, fixed-size picture filter to arbitrary dimensions, pixel width, operator choice and gapped input.

## Interface
- DW, 8, pixel width in bits (≥1)
- IMG_W, 225, input frame width in pixels (≥3)
- IMG_H, 225, input frame height in pixels (≥3)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a new frame and samples mode
- mode  in  2  operator: 0 median, 1 min, 2 max, 3 bypass (window centre)
- in_valid  in  1  qualifies in_data; no backpressure, any gap pattern allowed
- in_data  in  DW  input pixel, raster order
- busy  out  1  frame armed and not yet fully output
- out_valid  out  1  qualifies out_data, exactly one cycle per output pixel
- out_data  out  DW  filtered pixel
- out_eol  out  1  with out_valid: last pixel of an output row
- out_last  out  1  with out_valid: last pixel of the frame

## Operation
- Reset: busy=0, out_valid=0, out_data=0, out_eol=0, out_last=0. Column/row counters cleared and pipeline valid bits cleared. Line-buffer contents are don't-care.
- States: IDLE → RUN (on start) → DRAIN (last input accepted) → IDLE (after out_last).
- IDLE: in_valid is ignored. start samples mode into mode_r, clears counters, sets busy.
- RUN: each in_valid pixel is written at column c, row r:
  - The pixel is written into line buffer 0 at address c.
  - The previous buffer-0 content at c moves into line buffer 1.
  - A 3×3 window shift register advances one column.
  - c wraps IMG_W−1→0 and increments r.
- A window is complete when r≥2 and c≥2. It is centred on input (r−1, c−1) and produces output pixel (r−2, c−2).
- Operator: result = sorted[4] (median), sorted[0] (min), sorted[8] (max), or the centre pixel (bypass). Comparisons are unsigned DW-bit, and out_data is always one of the 9 window values.
- Accepting input pixel (IMG_W−1, IMG_H−1) moves the block to DRAIN. Further in_valid is ignored until the next start.
- out_eol is asserted when the output column equals IMG_W−3. out_last is asserted when additionally the output row equals IMG_H−3. busy deasserts on the cycle after out_last.
- start while busy aborts the current frame, flushes the pipeline (no further outputs from the old frame) and re-arms with the new mode.
- start while rst is high is ignored. rst has priority over everything.
- Total outputs per frame: exactly (IMG_W−2)×(IMG_H−2).

## Timing
- Fixed latency: out_valid occurs exactly 4 clk cycles after the rising edge that accepted the completing input pixel. That is 1 window register stage plus 3 pipelined sort stages.
- Latency is independent of input gaps. Outputs preserve input order, and output spacing mirrors input spacing for accepted window-completing pixels.
- Back-to-back in_valid yields back-to-back out_valid. There are no out_valid bubbles within a row except those caused by input gaps.
- Row wrap: the inputs at c=0 and c=1 of a row produce no output.
- Line-buffer read-before-write at the same address in the same cycle must return the old value.
- mode changes outside a start pulse have no effect on the frame in flight.
- The pipeline must sustain 1 pixel per clock at DW=8 with no multi-cycle paths.

## Test plan
- 5×5, DW=8, median, constant 0x40 input at full rate: 9 outputs, all 0x40. out_eol on outputs 3, 6 and 9; out_last on output 9. busy drops 1 cycle later.
- 5×5, median, single grain 0xFF at input (2,2), all others 0x00: all 9 outputs are 0x00.
- Same image with mode=max: all 9 outputs are 0xFF. With mode=min: all 0x00. With mode=bypass: only output (1,1) is 0xFF.
- 225×225, median, in_valid asserted 1 cycle in 4: exactly 223×223=49729 outputs, matching a software median reference. Each out_valid comes 4 cycles after its completing input.
- Reset mid-frame (after 12 pixels of a 5×5 frame): all outputs go to 0 the next cycle and busy=0. The following start plus a full frame yields a correct 9-pixel result.
- start re-issued mid-frame with a new mode: no stale outputs appear. The new frame's 9 outputs use the new operator.
